vote_recorder: RTL and testbench
================================

# vote_recorder

Front-end vote capture stage of the voting machine, directly upstream of the LED/mode control block. It synchronises and debounces the four raw candidate buttons and, in voting mode, registers exactly one vote per clean press into four saturating 8-bit tallies. It issues a one-cycle `valid_vote_casted` strobe per accepted vote. The tallies and debounced button levels feed the result-display logic downstream.

## Interface
- `DEBOUNCE_CYCLES`, default 10_000_000: consecutive synchronised cycles a button level must hold before the debounced level changes; legal values ≥ 1.
- `clock`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `mode`  input  1  0 = voting mode, 1 = result mode.
- `button1_raw`..`button4_raw`  input  1 each  raw, asynchronous, active-high candidate buttons.
- `candidate1_vote`..`candidate4_vote`  output  8 each  vote tallies, saturating at 255.
- `candidate1_button_press`..`candidate4_button_press`  output  1 each  debounced button levels.
- `valid_vote_casted`  output  1  one-cycle pulse on each accepted vote.

## Operation
- **Synchroniser:** each raw button passes through a 2-flop synchroniser (`s1` → `s2`).
- **Debouncer:** one counter per button, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - While `s2` differs from the debounced level, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and `s2` still differs, the debounced level takes `s2` and the counter clears.
  - If `s2` equals the debounced level, the counter clears (glitch rejection).
  - The debounced levels drive `candidateN_button_press` directly, in both modes.
- **Vote FSM:** two states, IDLE and WAIT_RELEASE.
  - IDLE, no debounced button high: stay in IDLE.
  - IDLE, `mode`=1, any debounced button high: go to WAIT_RELEASE with no vote. This prevents a press held across a mode change from counting.
  - IDLE, `mode`=0, exactly one debounced button high and its tally < 255: increment that tally, pulse `valid_vote_casted`, go to WAIT_RELEASE.
  - IDLE, `mode`=0, exactly one debounced button high and its tally = 255: no increment, no pulse, go to WAIT_RELEASE.
  - IDLE, `mode`=0, two or more debounced buttons high in the same cycle: ambiguous vote; nothing counted, no pulse, go to WAIT_RELEASE.
  - WAIT_RELEASE: stay until all four debounced levels are 0, then go to IDLE. Additional presses while in WAIT_RELEASE are ignored.
- **Tallies:** change only on an accepted vote or on reset. Mode changes never clear them.
- **Reset** (any time, including mid-press or mid-debounce), effective at the next edge:
  - synchronisers, debounce counters, debounced levels, all tallies and `valid_vote_casted` go to 0; FSM goes to IDLE.
  - A button still held after reset re-debounces and counts once (if `mode`=0).

## Timing
- **Reset values:** every output is 0.
- **Press latency:** raw button first sampled high at edge E0 and held high.
  - `s2` is high after edge E0+1.
  - `candidateN_button_press` is high after edge E0+DEBOUNCE_CYCLES+1.
  - Tally increment and `valid_vote_casted`=1 are both visible after edge E0+DEBOUNCE_CYCLES+2.
  - `valid_vote_casted` is high for exactly one cycle.
- **Release latency:** raw release follows the same path; the debounced level falls DEBOUNCE_CYCLES+1 edges after the first low sample. The FSM returns to IDLE on the next edge.
- **Minimum vote spacing:** two full debounce intervals plus 2 cycles.
- **Glitches:** a raw pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes the debounced level.
- **Simultaneity:** buttons whose debounced levels rise on the same edge are treated as simultaneous (no vote). Buttons whose debounced levels rise on different edges: the first counts and the later ones are ignored.

## Test plan
(all with DEBOUNCE_CYCLES=4)
- Reset, then in `mode`=0 hold `button2_raw` for 20 cycles and release → `candidate2_vote`=1, exactly one `valid_vote_casted` pulse, 6 edges after the first high sample; other tallies 0.
- `button1_raw` 3-cycle glitch → `candidate1_button_press` stays 0; no vote, no pulse.
- Assert `button3_raw` and `button4_raw` on the same cycle → no tally change and no pulse. After both are released, a single `button3` press → `candidate3_vote`=1.
- 257 clean `button1` presses in `mode`=0 → `candidate1_vote`=255; exactly 255 pulses; the last two presses produce no pulse.
- Hold `button2` in `mode`=1, switch to `mode`=0 while still held → no vote; `candidate2_button_press` follows the debounced level throughout. After release, the next press counts.
- Assert `reset` mid-debounce and again after 3 votes → all outputs 0 on the next edge. A press held through reset counts exactly once afterwards.

Source files
------------

// File: rtl/vote_recorder_if.sv
// Signal bundle between the vote capture stage and its environment: raw buttons and mode in,
// tallies, debounced levels and the vote strobe out.
interface vote_recorder_if;
   logic       mode;
   logic       button1_raw;
   logic       button2_raw;
   logic       button3_raw;
   logic       button4_raw;
   logic [7:0] candidate1_vote;
   logic [7:0] candidate2_vote;
   logic [7:0] candidate3_vote;
   logic [7:0] candidate4_vote;
   logic       candidate1_button_press;
   logic       candidate2_button_press;
   logic       candidate3_button_press;
   logic       candidate4_button_press;
   logic       valid_vote_casted;

   modport master (
      output mode, button1_raw, button2_raw, button3_raw, button4_raw,
      input  candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
      input  candidate1_button_press, candidate2_button_press,
      input  candidate3_button_press, candidate4_button_press,
      input  valid_vote_casted
   );

   modport slave (
      input  mode, button1_raw, button2_raw, button3_raw, button4_raw,
      output candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
      output candidate1_button_press, candidate2_button_press,
      output candidate3_button_press, candidate4_button_press,
      output valid_vote_casted
   );
endinterface

// File: rtl/vote_recorder.sv
// Vote capture: synchronise and debounce four candidate buttons, then record one vote per clean
// press into saturating 8-bit tallies, with a one-cycle strobe per accepted vote.
module vote_recorder #(
   parameter int unsigned DEBOUNCE_CYCLES = 10_000_000
) (
   input logic            clock,
   input logic            reset,
   vote_recorder_if.slave bus
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StWaitRelease} state_e;

   logic [3:0]      raw;
   logic [3:0]      s1_q, s1_d;
   logic [3:0]      s2_q, s2_d;
   logic [3:0]      db_q, db_d;
   logic [CntW-1:0] cnt_q [4];
   logic [CntW-1:0] cnt_d [4];
   logic [7:0]      tally_q [4];
   logic [7:0]      tally_d [4];
   logic            valid_q, valid_d;
   state_e          state_q, state_d;
   logic            single_high;

   assign raw = {bus.button4_raw, bus.button3_raw, bus.button2_raw, bus.button1_raw};

   // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      s1_d = raw;
      s2_d = s1_q;
      db_d = db_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               db_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntW'(1);
            end
         end
      end
      if (reset) begin
         s1_d = '0;
         s2_d = '0;
         db_d = '0;
         for (int i = 0; i < 4; i++) cnt_d[i] = '0;
      end
   end

   assign single_high = (db_q != 4'd0) && ((db_q & (db_q - 4'd1)) == 4'd0);

   always_comb begin
      state_d = state_q;
      valid_d = 1'b0;
      for (int i = 0; i < 4; i++) tally_d[i] = tally_q[i];
      unique case (state_q)
         StIdle: begin
            if (db_q != 4'd0) begin
               state_d = StWaitRelease;
               // Result mode or ambiguous multi-press: consume the press without voting.
               if (!bus.mode && single_high) begin
                  for (int i = 0; i < 4; i++) begin
                     if (db_q[i] && (tally_q[i] != 8'hFF)) begin
                        tally_d[i] = tally_q[i] + 8'd1;
                        valid_d    = 1'b1;
                     end
                  end
               end
            end
         end
         StWaitRelease: begin
            if (db_q == 4'd0) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (reset) begin
         state_d = StIdle;
         valid_d = 1'b0;
         for (int i = 0; i < 4; i++) tally_d[i] = '0;
      end
   end

   always_ff @(posedge clock) begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      state_q <= state_d;
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
         cnt_q[i]   <= cnt_d[i];
         tally_q[i] <= tally_d[i];
      end
   end

   assign bus.candidate1_vote         = tally_q[0];
   assign bus.candidate2_vote         = tally_q[1];
   assign bus.candidate3_vote         = tally_q[2];
   assign bus.candidate4_vote         = tally_q[3];
   assign bus.candidate1_button_press = db_q[0];
   assign bus.candidate2_button_press = db_q[1];
   assign bus.candidate3_button_press = db_q[2];
   assign bus.candidate4_button_press = db_q[3];
   assign bus.valid_vote_casted       = valid_q;

endmodule

// File: tb/tb_vote_recorder.sv
// Scoreboard bench for vote_recorder: stimulus pushes expected votes, a monitor checks each
// strobe against the queue; directed checks cover reset, glitches, ambiguity and saturation.
module tb_vote_recorder;

   localparam int DB = 4;

   typedef struct {
      int t1;
      int t2;
      int t3;
      int t4;
      int at_edge;
   } exp_t;

   logic clock;
   logic reset;
   int   edge_cnt;
   int   n_checks;
   int   n_fail;
   int   pulses;
   int   model [4];
   exp_t exp_q [$];

   vote_recorder_if vif ();

   vote_recorder #(.DEBOUNCE_CYCLES(DB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (vif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial edge_cnt = 0;
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe must match the oldest expected vote.
   always @(negedge clock) begin
      exp_t e;
      if (vif.valid_vote_casted) begin
         pulses++;
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("tally1", int'(vif.candidate1_vote), e.t1);
            check("tally2", int'(vif.candidate2_vote), e.t2);
            check("tally3", int'(vif.candidate3_vote), e.t3);
            check("tally4", int'(vif.candidate4_vote), e.t4);
            if (e.at_edge >= 0) check("vote_latency", edge_cnt, e.at_edge);
         end
      end
   end

   task automatic set_btn(input int idx, input logic v);
      case (idx)
         0: vif.button1_raw = v;
         1: vif.button2_raw = v;
         2: vif.button3_raw = v;
         default: vif.button4_raw = v;
      endcase
   endtask

   task automatic push_exp(input int at_edge);
      exp_t e;
      e = '{t1: model[0], t2: model[1], t3: model[2], t4: model[3], at_edge: at_edge};
      exp_q.push_back(e);
   endtask

   // One clean press; pushes an expected vote when it should count.
   task automatic press(input int idx, input bit lat, input int hold);
      @(negedge clock);
      if (vif.mode == 1'b0 && model[idx] < 255) begin
         model[idx]++;
         push_exp(lat ? edge_cnt + DB + 3 : -1);
      end
      set_btn(idx, 1'b1);
      repeat (hold) @(negedge clock);
      set_btn(idx, 1'b0);
      repeat (12) @(negedge clock);
   endtask

   function automatic int outputs_sum();
      return int'(vif.candidate1_vote) + int'(vif.candidate2_vote) + int'(vif.candidate3_vote)
           + int'(vif.candidate4_vote) + int'(vif.candidate1_button_press)
           + int'(vif.candidate2_button_press) + int'(vif.candidate3_button_press)
           + int'(vif.candidate4_button_press) + int'(vif.valid_vote_casted);
   endfunction

   task automatic do_reset(input string name);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check(name, outputs_sum(), 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 0;
   endtask

   initial begin
      int p0;
      int seen;
      n_checks = 0;
      n_fail   = 0;
      pulses   = 0;
      for (int i = 0; i < 4; i++) model[i] = 0;
      reset = 1'b1;
      vif.mode = 1'b0;
      vif.button1_raw = 1'b0;
      vif.button2_raw = 1'b0;
      vif.button3_raw = 1'b0;
      vif.button4_raw = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_outputs", outputs_sum(), 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Single press of button2 with latency check.
      press(1, 1'b1, 20);
      check("b2_tally", int'(vif.candidate2_vote), 1);
      check("b2_pulses", pulses, 1);
      check("b2_others", int'(vif.candidate1_vote) + int'(vif.candidate3_vote)
                         + int'(vif.candidate4_vote), 0);

      // 3-cycle glitch on button1.
      p0 = pulses;
      seen = 0;
      @(negedge clock);
      vif.button1_raw = 1'b1;
      repeat (3) @(negedge clock);
      vif.button1_raw = 1'b0;
      repeat (12) begin
         if (vif.candidate1_button_press) seen = 1;
         @(negedge clock);
      end
      check("glitch_level", seen, 0);
      check("glitch_pulse", pulses - p0, 0);
      check("glitch_tally", int'(vif.candidate1_vote), 0);

      // Simultaneous button3 and button4.
      p0 = pulses;
      @(negedge clock);
      vif.button3_raw = 1'b1;
      vif.button4_raw = 1'b1;
      repeat (12) @(negedge clock);
      vif.button3_raw = 1'b0;
      vif.button4_raw = 1'b0;
      repeat (12) @(negedge clock);
      check("simul_pulse", pulses - p0, 0);
      check("simul_tally", int'(vif.candidate3_vote) + int'(vif.candidate4_vote), 0);
      press(2, 1'b0, 10);
      check("b3_after_simul", int'(vif.candidate3_vote), 1);

      // 257 presses of button1; the last two saturate.
      p0 = pulses;
      for (int k = 0; k < 257; k++) press(0, 1'b0, 10);
      check("sat_tally", int'(vif.candidate1_vote), 255);
      check("sat_pulses", pulses - p0, 255);

      // Press held across a result-to-voting mode change.
      p0 = pulses;
      @(negedge clock);
      vif.mode = 1'b1;
      vif.button2_raw = 1'b1;
      repeat (8) @(negedge clock);
      check("mode_level_high", int'(vif.candidate2_button_press), 1);
      vif.mode = 1'b0;
      repeat (10) @(negedge clock);
      check("mode_level_held", int'(vif.candidate2_button_press), 1);
      vif.button2_raw = 1'b0;
      repeat (12) @(negedge clock);
      check("mode_level_low", int'(vif.candidate2_button_press), 0);
      check("mode_no_vote", pulses - p0, 0);
      check("mode_tally", int'(vif.candidate2_vote), 1);
      press(1, 1'b0, 10);
      check("mode_next_vote", int'(vif.candidate2_vote), 2);

      // Reset mid-debounce with the button still held: counts once afterwards.
      @(negedge clock);
      vif.button1_raw = 1'b1;
      repeat (2) @(negedge clock);
      do_reset("reset_mid_debounce");
      model[0] = 1;
      push_exp(-1);
      repeat (12) @(negedge clock);
      vif.button1_raw = 1'b0;
      repeat (12) @(negedge clock);
      check("held_through_reset", int'(vif.candidate1_vote), 1);

      // Three votes then reset.
      press(1, 1'b0, 10);
      press(2, 1'b0, 10);
      press(3, 1'b0, 10);
      do_reset("reset_after_votes");

      repeat (10) @(negedge clock);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
